dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/riscv_isa_pkg.sv | 26 ++
 rtl/uarch_pkg.sv | 18 +
 rtl/resp_fifo.sv | 68 ++++++
 rtl/dmem_responder.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/riscv_isa_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_isa_pkg
//  Purpose  : ISA-level types shared by the memory pipeline
//  Revision : 1.0 - initial release
// ============================================================================
package riscv_isa_pkg;

  // Access size of a load/store.
  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_size_t;

  // The raw encoding 3 is not a legal size; it behaves as a full word.
  function automatic mem_size_t to_mem_size(input logic [1:0] raw);
    case (raw)
      2'd0:    return BYTE;
      2'd1:    return HALF;
      default: return WORD;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/uarch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uarch_pkg
//  Purpose  : Micro-architecture wide widths and writeback packet format
//  Revision : 1.0 - initial release
// ============================================================================
package uarch_pkg;

  localparam int TAG_WIDTH = 6;

  typedef struct packed {
    logic                 is_valid;
    logic [TAG_WIDTH-1:0] dest_tag;
    logic [31:0]          result;
  } writeback_packet_t;

endpackage
`default_nettype wire

// File: rtl/resp_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : resp_fifo
//  Purpose  : Small power-of-two response FIFO with flush clear
//  Revision : 1.0 - initial release
// ============================================================================
module resp_fifo #(
  parameter int WIDTH = 38,
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    enq,
  input  logic [WIDTH-1:0]        enq_data,
  input  logic                    deq,
  output logic [WIDTH-1:0]        head_data,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_enq;
  logic             do_deq;

  // A flush wins over both ends so nothing in flight survives it.
  assign do_enq    = enq && !flush;
  assign do_deq    = deq && (count != '0) && !flush;
  assign head_data = storage[rd_ptr];

  // Payload storage; contents beyond the count are don't-care, so no reset.
  always_ff @(posedge clk) begin
    if (do_enq) storage[wr_ptr] <= enq_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_enq) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_deq) rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_enq, do_deq})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // The producer's credit scheme must never push into a full FIFO.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(enq && !flush && (count == FULL_CNT)));

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_responder
//  Purpose  : Data memory with 2-cycle load pipeline and credited response
//             FIFO toward the writeback stage
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_responder
  import uarch_pkg::*;
  import riscv_isa_pkg::*;
#(
  parameter int MEM_WORDS  = 1024,
  parameter int RESP_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 req_valid,
  output logic                 req_rdy,
  input  logic                 req_is_store,
  input  logic [31:0]          req_addr,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [31:0]          req_wdata,
  input  logic [TAG_WIDTH-1:0] req_dest_tag,
  output writeback_packet_t    dmem_rec_packet,
  input  logic                 dmem_rec_rdy
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = $clog2(RESP_DEPTH) + 1;
  localparam int FW = TAG_WIDTH + 32;
  localparam logic [CW:0] CREDITS = (CW+1)'(RESP_DEPTH);

  logic [31:0]          mem [MEM_WORDS];
  logic [AW-1:0]        word_idx;
  mem_size_t            req_sz;
  logic [3:0]           byte_en;
  logic [31:0]          wr_lanes;
  logic                 accept;
  logic                 store_acc;
  logic                 load_acc;
  logic [CW-1:0]        fifo_count;
  logic [CW:0]          used;
  logic                 unused_addr;

  // S1 state: one load between array read and FIFO write.
  logic                 inflight;
  logic [31:0]          rd_word;
  logic [TAG_WIDTH-1:0] s1_tag;
  mem_size_t            s1_size;
  logic [1:0]           s1_off;
  logic                 s1_unsigned;

  logic [31:0]          shifted;
  logic [31:0]          load_result;
  logic [FW-1:0]        head_data;

  assign word_idx    = req_addr[AW+1:2];
  assign unused_addr = ^req_addr[31:AW+2];
  assign req_sz      = to_mem_size(req_size);

  // Credits use registered counts only; a same-cycle dequeue is not counted.
  assign used      = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
  assign req_rdy   = rst_n && !flush && (used < CREDITS);
  assign accept    = req_valid && req_rdy;
  assign store_acc = accept && req_is_store;
  assign load_acc  = accept && !req_is_store;

  // Store byte enables and lane replication of right-aligned store data.
  always_comb begin
    byte_en  = 4'hF;
    wr_lanes = req_wdata;
    case (req_sz)
      BYTE: begin
        byte_en  = 4'b0001 << req_addr[1:0];
        wr_lanes = {4{req_wdata[7:0]}};
      end
      HALF: begin
        byte_en  = req_addr[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{req_wdata[15:0]}};
      end
      default: begin
        byte_en  = 4'hF;
        wr_lanes = req_wdata;
      end
    endcase
  end

  // Array write with byte enables; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (store_acc) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= wr_lanes[8*b +: 8];
      end
    end
  end

  // Synchronous array read for an accepted load.
  always_ff @(posedge clk) begin
    if (load_acc) rd_word <= mem[word_idx];
  end

  // S1 control registers; a flush blocks acceptance, which cancels inflight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight    <= 1'b0;
      s1_tag      <= '0;
      s1_size     <= BYTE;
      s1_off      <= 2'b00;
      s1_unsigned <= 1'b0;
    end else begin
      inflight <= load_acc;
      if (load_acc) begin
        s1_tag      <= req_dest_tag;
        s1_size     <= req_sz;
        s1_off      <= req_addr[1:0];
        s1_unsigned <= req_unsigned;
      end
    end
  end

  assign shifted = rd_word >> {s1_off, 3'b000};

  // S2 load formatting: align, mask to size, then sign or zero extend.
  always_comb begin
    load_result = shifted;
    case (s1_size)
      BYTE:    load_result = {{24{!s1_unsigned && shifted[7]}},  shifted[7:0]};
      HALF:    load_result = {{16{!s1_unsigned && shifted[15]}}, shifted[15:0]};
      default: load_result = shifted;
    endcase
  end

  resp_fifo #(
    .WIDTH (FW),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .enq       (inflight),
    .enq_data  ({s1_tag, load_result}),
    .deq       (dmem_rec_packet.is_valid && dmem_rec_rdy),
    .head_data (head_data),
    .count     (fifo_count)
  );

  assign dmem_rec_packet.is_valid = (fifo_count != '0);
  assign dmem_rec_packet.dest_tag = head_data[FW-1:32];
  assign dmem_rec_packet.result   = head_data[31:0];

endmodule
`default_nettype wire
